// File: rtl/bus_arbiter_8req_pkg.sv
// Shared constants, state encoding and helpers for the 8-requester bus arbiter.
package arb_pkg;

  localparam int unsigned N_REQ     = 8;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned MAX_HOLD  = 4;
  localparam int unsigned HOLD_W    = 4;
  localparam int unsigned FETCH_REQ = 0;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  typedef logic [N_REQ-1:0] req_vec_t;

  // One-hot vector with the bit at idx set.
  function automatic req_vec_t onehot(input logic [SEL_W-1:0] idx);
    req_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_arbiter_8req_if.sv
// Request/grant bundle between the requesters and the bus arbiter.
// master: requester side (drives req). slave: arbiter side (drives grant/select).
interface bus_arbiter_8req_if;
  import arb_pkg::*;

  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  grant;
  logic [SEL_W-1:0]  sel;
  logic              bus_valid;
  logic [HOLD_W-1:0] hold_cnt;

  modport master (
    output req,
    input  grant,
    input  sel,
    input  bus_valid,
    input  hold_cnt
  );

  modport slave (
    input  req,
    output grant,
    output sel,
    output bus_valid,
    output hold_cnt
  );

endinterface

// File: rtl/bus_arbiter_8req_rr_pick8.sv
// Masked round-robin priority encoder: first eligible request at or above
// i_start (wrapping 7->0), with requests in i_excl ignored.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_start,
  input  logic [N_REQ-1:0] i_excl,
  output logic             o_found,
  output logic [SEL_W-1:0] o_idx
);

  logic [N_REQ-1:0] w_elig;
  logic [SEL_W-1:0] w_cand;

  assign w_elig = i_req & ~i_excl;

  // Scan upward from the start pointer; the 3-bit candidate wraps naturally.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand = i_start + SEL_W'(k);
      if (!o_found && w_elig[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_8req.sv
// Round-robin arbiter for the 8-input, 24-bit CPU datapath bus mux.
// Registered one-hot grant plus mux select, with a tenure limit so no
// requester can starve the others.
// Optional: define ARB_FETCH_PRIORITY_EN to give requester 0 (instruction
// fetch) pre-emptive priority over any other owner.
module bus_arbiter_8req
  import arb_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  bus_arbiter_8req_if.slave   io_bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [SEL_W-1:0]  r_ptr;
  logic [SEL_W-1:0]  w_ptr_nxt;
  logic [N_REQ-1:0]  r_grant;
  logic [N_REQ-1:0]  w_grant_nxt;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_bus_valid;

  logic              w_found;
  logic [SEL_W-1:0]  w_pick;
  logic              w_owner_req;
  logic              w_fetch_take;
  logic              w_take;

  // The current grant doubles as the exclude mask: empty when idle, the
  // owner's bit when owned, so a release never re-picks the releasing owner.
  rr_pick8 u_pick (
    .i_req   (io_bus.req),
    .i_start (r_ptr),
    .i_excl  (r_grant),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_owner_req = io_bus.req[r_sel];

`ifdef ARB_FETCH_PRIORITY_EN
  assign w_fetch_take = (r_state == OWN) && io_bus.req[FETCH_REQ] &&
                        (r_sel != SEL_W'(FETCH_REQ));
`else
  assign w_fetch_take = 1'b0;
`endif

  // Next-state, next-grant and tenure counter decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_hold_nxt  = r_hold;
    w_ptr_nxt   = r_ptr;
    w_take      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_take = 1'b1;
        end
      end
      OWN: begin
        if (w_fetch_take) begin
          // Fetch pre-emption leaves Ptr alone so round-robin order resumes.
          w_grant_nxt = onehot(SEL_W'(FETCH_REQ));
          w_sel_nxt   = SEL_W'(FETCH_REQ);
          w_hold_nxt  = '0;
        end else if (!w_owner_req) begin
          if (w_found) begin
            w_take = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_sel_nxt   = '0;
            w_hold_nxt  = '0;
          end
        end else if (r_hold < HOLD_LAST) begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end else if (w_found) begin
          w_take = 1'b1;
        end
        // Otherwise: tenure expired but nobody else waits; keep and saturate.
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_sel_nxt   = '0;
        w_hold_nxt  = '0;
      end
    endcase

    if (w_take) begin
      w_state_nxt = OWN;
      w_grant_nxt = onehot(w_pick);
      w_sel_nxt   = w_pick;
      w_hold_nxt  = '0;
      w_ptr_nxt   = w_pick + SEL_W'(1);
    end
  end

  // State, pointer and registered outputs; async reset drops the grant at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_sel       <= '0;
      r_hold      <= '0;
      r_bus_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_sel       <= w_sel_nxt;
      r_hold      <= w_hold_nxt;
      r_bus_valid <= |w_grant_nxt;
    end
  end

  assign io_bus.grant     = r_grant;
  assign io_bus.sel       = r_sel;
  assign io_bus.bus_valid = r_bus_valid;
  assign io_bus.hold_cnt  = r_hold;

endmodule
